// File: rtl/riscv_defs.sv
// Shared constants for the pipelined RISC-V core: opcodes, the canonical NOP
// and the payload width of each inter-stage register.
package riscv_defs;

   localparam logic [6:0]  OPCODE_I = 7'b001_0011;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;   // addi x0,x0,0

   localparam int unsigned IFID_W  = 96;
   localparam int unsigned IDEX_W  = 160;
   localparam int unsigned EXMEM_W = 112;
   localparam int unsigned MEMWB_W = 80;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over inc.
// Reusable for any performance counter that must never wrap.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (clear) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional two-entry
// skid buffer (registered in_ready), bubble payload and a stall counter.
module pipe_stage_reg
   import riscv_defs::*;
#(
   parameter int unsigned       DATA_W    = IFID_W,
   parameter logic [DATA_W-1:0] NOP_VALUE = DATA_W'({64'b0, NOP_INST}),
   parameter bit                SKID      = 1'b1,
   parameter int unsigned       CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [1:0]        dbg_state
);

   // Handshake: a side transfers on a cycle where its valid and ready are both
   // high at the rising edge; flush and rst discard the same-cycle input.

   logic stall_inc;

   if (SKID) begin : g_skid
      typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_t;

      occ_t              state_q, state_d;
      logic              in_ready_q;
      logic [DATA_W-1:0] main_q, skid_q;
      logic              in_xfer, out_xfer;

      assign in_xfer  = in_valid && in_ready_q;
      assign out_xfer = (state_q != EMPTY) && out_ready;

      always_ff @(posedge clk) begin
         if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
         end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
         end
      end

      always_comb begin
         state_d = state_q;
         if (flush) begin
            state_d = EMPTY;
         end else begin
            case (state_q)
               EMPTY:   if (in_xfer) state_d = ONE;
               ONE: begin
                  if (in_xfer && !out_xfer)      state_d = FULL;
                  else if (!in_xfer && out_xfer) state_d = EMPTY;
               end
               FULL:    if (out_xfer) state_d = ONE;
               default: state_d = EMPTY;
            endcase
         end
      end

      always_comb begin
         out_valid = (state_q != EMPTY);
         out_data  = main_q;
         in_ready  = in_ready_q;
         dbg_state = state_q;
      end

      // main_q always drives out_data, so it is returned to the bubble on empty.
      always_ff @(posedge clk) begin
         if (rst || flush) begin
            main_q <= NOP_VALUE;
            skid_q <= NOP_VALUE;
         end else begin
            case (state_q)
               EMPTY: if (in_xfer) main_q <= in_data;
               ONE: begin
                  if (in_xfer && out_xfer) main_q <= in_data;
                  else if (in_xfer)        skid_q <= in_data;
                  else if (out_xfer)       main_q <= NOP_VALUE;
               end
               FULL: begin
                  if (out_xfer) begin
                     main_q <= skid_q;
                     skid_q <= NOP_VALUE;
                  end
               end
               default: ;
            endcase
         end
      end
   end else begin : g_single
      logic              valid_q;
      logic [DATA_W-1:0] data_q;
      logic              in_xfer, out_xfer;

      assign in_ready = out_ready || !valid_q;
      assign in_xfer  = in_valid && in_ready;
      assign out_xfer = valid_q && out_ready;

      always_ff @(posedge clk) begin
         if (rst || flush) begin
            valid_q <= 1'b0;
            data_q  <= NOP_VALUE;
         end else if (in_xfer) begin
            valid_q <= 1'b1;
            data_q  <= in_data;
         end else if (out_xfer) begin
            valid_q <= 1'b0;
            data_q  <= NOP_VALUE;
         end
      end

      assign out_valid = valid_q;
      assign out_data  = data_q;
      assign dbg_state = {1'b0, valid_q};
   end

   assign stall_inc = out_valid && !out_ready && !flush;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .clear (rst),
      .inc   (stall_inc),
      .count (stall_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid (SKID=1) and single-register (SKID=0, CNT_W=4)
// instances driven side by side and compared against a queue-based model.
module tb_pipe_stage_reg;

  localparam int W = 96;
  localparam logic [W-1:0] NOP = {64'b0, 32'h0000_0013};

  logic clk;
  logic rst;
  logic flush1, iv1, or1;
  logic [W-1:0] id1;
  logic flush0, iv0, or0;
  logic [W-1:0] id0;

  logic in_ready1, out_valid1;
  logic [W-1:0] out_data1;
  logic [15:0] stall_cnt1;
  logic [1:0] dbg1;
  logic in_ready0, out_valid0;
  logic [W-1:0] out_data0;
  logic [3:0] stall_cnt0;
  logic [1:0] dbg0;

  int n_checks = 0;
  int n_fail = 0;
  int acc1 = 0;

  // scoreboard: expected contents of each stage, oldest first
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q0[$];
  int cnt1 = 0;
  int cnt0 = 0;

  pipe_stage_reg #(.SKID(1'b1)) u_s1 (
    .clk(clk), .rst(rst), .flush(flush1),
    .in_valid(iv1), .in_ready(in_ready1), .in_data(id1),
    .out_valid(out_valid1), .out_ready(or1), .out_data(out_data1),
    .stall_cnt(stall_cnt1), .dbg_state(dbg1)
  );

  pipe_stage_reg #(.SKID(1'b0), .CNT_W(4)) u_s0 (
    .clk(clk), .rst(rst), .flush(flush0),
    .in_valid(iv0), .in_ready(in_ready0), .in_data(id0),
    .out_valid(out_valid0), .out_ready(or0), .out_data(out_data0),
    .stall_cnt(stall_cnt0), .dbg_state(dbg0)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check ready before the edge, advance the model, check outputs after.
  task automatic step();
    logic e_rdy1, e_rdy0, stall;
    #1;
    e_rdy1 = (exp_q1.size() < 2);
    e_rdy0 = or0 || (exp_q0.size() == 0);
    check("s1_in_ready", {95'b0, in_ready1}, {95'b0, e_rdy1});
    check("s0_in_ready", {95'b0, in_ready0}, {95'b0, e_rdy0});
    if (iv1 && e_rdy1 && !flush1 && !rst) acc1++;
    @(posedge clk);
    stall = (exp_q1.size() > 0) && !or1 && !flush1;
    if (rst) begin
      exp_q1.delete();
      cnt1 = 0;
    end else begin
      if (stall && cnt1 < 65535) cnt1++;
      if (flush1) exp_q1.delete();
      else begin
        if (exp_q1.size() > 0 && or1) void'(exp_q1.pop_front());
        if (iv1 && e_rdy1) exp_q1.push_back(id1);
      end
    end
    stall = (exp_q0.size() > 0) && !or0 && !flush0;
    if (rst) begin
      exp_q0.delete();
      cnt0 = 0;
    end else begin
      if (stall && cnt0 < 15) cnt0++;
      if (flush0) exp_q0.delete();
      else begin
        if (exp_q0.size() > 0 && or0) void'(exp_q0.pop_front());
        if (iv0 && e_rdy0) exp_q0.push_back(id0);
      end
    end
    #1;
    check("s1_out_valid", {95'b0, out_valid1}, {95'b0, exp_q1.size() > 0});
    check("s1_out_data", out_data1, (exp_q1.size() > 0) ? exp_q1[0] : NOP);
    check("s1_stall_cnt", {80'b0, stall_cnt1}, W'(cnt1));
    check("s1_occupancy", {94'b0, dbg1}, W'(exp_q1.size()));
    check("s0_out_valid", {95'b0, out_valid0}, {95'b0, exp_q0.size() > 0});
    check("s0_out_data", out_data0, (exp_q0.size() > 0) ? exp_q0[0] : NOP);
    check("s0_stall_cnt", {92'b0, stall_cnt0}, W'(cnt0));
  endtask

  function automatic logic [W-1:0] payload(input logic [31:0] pc, input logic [31:0] inst);
    return {pc + 32'd4, pc, inst};
  endfunction

  function automatic logic [W-1:0] rnd_payload();
    return {$urandom, $urandom, $urandom};
  endfunction

  initial begin
    int acc_before;
    int cnt_before;
    logic [W-1:0] flushed;
    rst = 1'b1;
    flush1 = 1'b0; iv1 = 1'b0; or1 = 1'b1; id1 = '0;
    flush0 = 1'b0; iv0 = 1'b0; or0 = 1'b1; id0 = '0;
    @(posedge clk);
    #1;

    // reset values, with the first payload already presented
    iv1 = 1'b1;
    id1 = payload(32'h0000_1000, 32'h00A0_0093);
    step();
    check("reset_out_data", out_data1, NOP);
    check("reset_in_ready", {95'b0, in_ready1}, {95'b0, 1'b1});
    rst = 1'b0;
    step();
    check("first_latency", out_data1, payload(32'h0000_1000, 32'h00A0_0093));

    // streaming: 8 sequential payloads at full rate
    for (int i = 0; i < 8; i++) begin
      id1 = payload(32'h0000_2000 + 32'(4 * i), 32'h0010_0093 + 32'(i << 20));
      iv0 = 1'b1;
      id0 = id1;
      step();
      check("stream_s1_order", out_data1, id1);
      check("stream_s0_order", out_data0, id0);
    end

    // skid backpressure: exactly one more input, then in_ready low
    acc_before = acc1;
    cnt_before = cnt1;
    iv0 = 1'b0;
    or1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      id1 = payload(32'h0000_3000 + 32'(4 * i), 32'h0020_0093);
      step();
    end
    check("bp_one_more_accepted", W'(acc1 - acc_before), W'(1));
    check("bp_in_ready_low", {95'b0, in_ready1}, 96'd0);
    check("bp_stall_cnt", {80'b0, stall_cnt1}, W'(cnt_before + 3));
    iv1 = 1'b0;
    or1 = 1'b1;
    repeat (3) step();

    // flush in FULL with a same-cycle input
    or1 = 1'b0;
    iv1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      id1 = payload(32'h0000_4000 + 32'(4 * i), 32'h0030_0093);
      step();
    end
    check("full_before_flush", {94'b0, dbg1}, W'(2));
    flush1 = 1'b1;
    flushed = payload(32'h0000_5000, 32'h0040_0093);
    id1 = flushed;
    step();
    check("flush_out_valid", {95'b0, out_valid1}, 96'd0);
    check("flush_out_data", out_data1, NOP);
    check("flush_in_ready", {95'b0, in_ready1}, {95'b0, 1'b1});
    flush1 = 1'b0;
    iv1 = 1'b0;
    or1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      assert (out_data1 !== flushed) else begin
        n_fail++;
        $error("FAIL flush_no_leak: observed %0h expected not %0h", out_data1, flushed);
      end
      n_checks++;
    end

    // single register: 4-cycle pause keeps the held payload
    iv0 = 1'b1;
    id0 = payload(32'h0000_6000, 32'h0050_0093);
    step();
    for (int i = 0; i < 4; i++) begin
      or0 = 1'b0;
      id0 = payload(32'h0000_7000 + 32'(4 * i), 32'h0060_0093);
      step();
      check("s0_pause_in_ready", {95'b0, in_ready0}, {95'b0, or0});
      check("s0_pause_held", out_data0, payload(32'h0000_6000, 32'h0050_0093));
    end
    or0 = 1'b1;
    iv0 = 1'b0;
    step();

    // saturation of the 4-bit counter, then reset clears it
    iv0 = 1'b1;
    id0 = payload(32'h0000_8000, 32'h0070_0093);
    step();
    iv0 = 1'b0;
    or0 = 1'b0;
    repeat (20) step();
    check("sat_value", {92'b0, stall_cnt0}, W'(15));
    step();
    check("sat_holds", {92'b0, stall_cnt0}, W'(15));
    rst = 1'b1;
    step();
    check("sat_reset_clear", {92'b0, stall_cnt0}, 96'd0);
    rst = 1'b0;
    or0 = 1'b1;

    // randomized traffic on both instances
    for (int i = 0; i < 400; i++) begin
      iv1 = 1'($urandom_range(0, 1));
      or1 = ($urandom_range(0, 3) != 0);
      flush1 = ($urandom_range(0, 24) == 0);
      id1 = rnd_payload();
      iv0 = 1'($urandom_range(0, 1));
      or0 = ($urandom_range(0, 3) != 0);
      flush0 = ($urandom_range(0, 24) == 0);
      id0 = rnd_payload();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the pipelined CPU. It replaces the fixed-width, pause/flush-only stage latches with a valid/ready handshake, an optional two-entry skid buffer that registers the upstream ready, and a configurable bubble payload. One instance sits between each pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB), sized per boundary by `DATA_W`.

## Interface
- `DATA_W`, default 96: payload width in bits. The IF/ID default packs pc+4 in [95:64], pc in [63:32] and inst in [31:0].
- `NOP_VALUE`, default {64'b0, 32'h0000_0013}: payload presented when the stage is empty, after flush, or after reset. The default is the RISC-V `addi x0,x0,0` encoding.
- `SKID`, default 1: selects the buffer mode.
  - 1: two-entry skid buffer; `in_ready` is registered.
  - 0: single register; `in_ready` is combinational.
- `CNT_W`, default 16: width of the stall-cycle counter.
- `clk  in  1`: clock. All state updates on the rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `flush  in  1`: synchronous squash of all held entries.
- `in_valid  in  1`: upstream stage presents `in_data`.
- `in_ready  out  1`: this stage accepts `in_data` this cycle.
- `in_data  in  DATA_W`: upstream payload.
- `out_valid  out  1`: `out_data` holds a real instruction.
- `out_ready  in  1`: downstream accepts `out_data` this cycle. Driving it low implements Pause.
- `out_data  out  DATA_W`: payload toward the downstream stage. Equals `NOP_VALUE` whenever `out_valid`=0.
- `stall_cnt  out  CNT_W`: saturating count of cycles with `out_valid`=1 and `out_ready`=0.

## Operation
- A transfer happens on the input side when `in_valid`&&`in_ready` and on the output side when `out_valid`&&`out_ready`.
- **SKID=1**: occupancy FSM with states EMPTY(0), ONE(1) and FULL(2). It holds a main entry (which drives `out_data`) and a skid entry.
  - EMPTY: input transfer → ONE, with data loaded into main.
  - ONE, input only → FULL, with data loaded into skid.
  - ONE, output only → EMPTY.
  - ONE, both → ONE, with main replaced by the input.
  - ONE, neither → ONE, main held.
  - FULL: `in_ready`=0. Output transfer → ONE, with skid moved into main.
  - `in_ready` is a register: it is 1 exactly when the next state is not FULL.
- **SKID=0**: a single entry.
  - `in_ready` = `out_ready` || !`out_valid`.
  - On an input transfer the entry loads.
  - On an output transfer with no input transfer the entry empties.
- Ordering is strict FIFO; no payload is duplicated or lost except by flush.
- **Flush**: has priority over every handshake.
  - Next state is EMPTY.
  - The same-cycle input is discarded, even if `in_ready` was 1.
  - `out_data` becomes `NOP_VALUE` and `in_ready` becomes 1.
- **Reset**: identical effect to flush, plus `stall_cnt` clears to 0. `rst` overrides `flush`.
- **stall_cnt**: increments by 1 on each cycle with `out_valid`&&!`out_ready`&&!`flush`. It saturates at 2^CNT_W−1 and never wraps. Flush does not clear it.

## Timing
- Reset values:
  - `out_valid`=0
  - `out_data`=`NOP_VALUE`
  - `in_ready`=1 in both modes, since it depends only on `out_valid` when empty
  - `stall_cnt`=0
  - state EMPTY
- Latency: one cycle from the input transfer edge to `out_valid`=1 with that payload.
- Throughput: one transfer per cycle in both modes while `out_ready`=1.
- SKID=1: `in_ready` has no combinational path from `out_ready`. After `out_ready` deasserts, the stage absorbs exactly one further input before `in_ready` falls.
- SKID=0: `in_ready` follows `out_ready` in the same cycle.
- `out_data` and `out_valid` are registered in both modes; there is no combinational path from `in_*` to `out_*`.
- `flush` asserted in FULL discards both entries in one cycle.
- `flush` and `rst` asserted in the same cycle as `out_ready`: the downstream transfer still counts that cycle. The downstream stage must qualify with its own flush.

## Structure
- Shared package `riscv_defs` carries:
  - `OPCODE_I`
  - the `NOP_INST` constant (32'h0000_0013)
  - the per-boundary payload width constants `IFID_W`, `IDEX_W`, `EXMEM_W` and `MEMWB_W`
- Occupancy encoding is local to the module (2-bit: EMPTY=0, ONE=1, FULL=2).
- One natural sub-module is `sat_counter` (parameter `W`, with clear and inc inputs) for `stall_cnt`. It is reusable for other performance counters.
- The mode split uses a generate on `SKID`. No other hierarchy.

## Test plan
- Reset, then `in_valid`=1 with `in_data`=0x…_00A0_0093 and `out_ready`=1. Expect:
  - `out_valid`=1 with that payload one cycle later
  - `out_data`=`NOP_VALUE` and `in_ready`=1 during reset
- Streaming: feed 8 sequential payloads with `out_ready` held at 1. Expect 8 outputs in order on consecutive cycles, with `in_ready` never 0.
- SKID=1 backpressure: drop `out_ready` with a stream active. Expect:
  - exactly one more input accepted, then `in_ready`=0
  - on re-raising `out_ready`, both held payloads emerge in order
  - `stall_cnt` equals the number of low cycles
- Flush in FULL with `in_valid`=1. Expect next cycle `out_valid`=0, `out_data`=`NOP_VALUE` and `in_ready`=1. The flushed-cycle input never appears at the output.
- SKID=0, 4-cycle pause. Expect `in_ready` equal to `out_ready` each cycle and the held payload unchanged throughout.
- Saturation: CNT_W=4 with a stall of 20 cycles. Expect `stall_cnt`=15 that holds, and reset clears it to 0.
